// File: rtl/pe_operand_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pe_operand_sequencer
// Description : Per-PE instruction sequencer. Fetches and decodes words, stalls
//               until the neighbour/bus operands are present, then issues the
//               op_selector selects, ALU op and destination, popping the FIFOs.
//               Optional build macro STALL_CNT_EN adds a saturating WAIT-cycle
//               counter on output stall_cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_operand_sequencer #(
    parameter int ADDR_W = 8,
    parameter int INST_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] prog_len,
    output logic              inst_rd,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic [INST_W-1:0] inst_data,
    input  logic              neigh_valid,
    output logic              neigh_pop,
    input  logic              bus_valid,
    output logic              bus_pop,
    output logic [2:0]        sel0,
    output logic [2:0]        sel1,
    output logic [2:0]        alu_op,
    output logic [2:0]        dst,
    output logic              issue,
    output logic              busy,
    output logic              done
`ifdef STALL_CNT_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    localparam logic [2:0]        c_sel_neigh = 3'd6;
    localparam logic [2:0]        c_sel_bus   = 3'd7;
    localparam logic [ADDR_W-1:0] c_one       = 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_WAIT   = 3'd3,
        S_ISSUE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_len;
    logic [INST_W-1:0] r_ir;

    logic w_start_acc;
    logic w_pc_inc;
    logic w_ir_load;
    logic w_last;

    // A word is ready when every FIFO named by either select has data.
    function automatic logic operands_ready(input logic [2:0] a, input logic [2:0] b,
                                            input logic nv, input logic bv);
        operands_ready = ((a != c_sel_neigh && b != c_sel_neigh) || nv) &&
                         ((a != c_sel_bus   && b != c_sel_bus)   || bv);
    endfunction

    assign w_last    = (r_pc == r_len - c_one);
    assign inst_addr = r_pc;
    assign busy      = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_pc_inc    = 1'b0;
        w_ir_load   = 1'b0;
        inst_rd     = 1'b0;
        issue       = 1'b0;
        neigh_pop   = 1'b0;
        bus_pop     = 1'b0;
        sel0        = 3'd0;
        sel1        = 3'd0;
        alu_op      = 3'd0;
        dst         = 3'd0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = (prog_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                inst_rd     = 1'b1;
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                w_ir_load = 1'b1;
                if (inst_data[11:9] == 3'd0) begin
                    // NOP retires straight from decode without touching the FIFOs
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_pc_inc    = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                end else if (operands_ready(inst_data[8:6], inst_data[5:3], neigh_valid, bus_valid)) begin
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (operands_ready(r_ir[8:6], r_ir[5:3], neigh_valid, bus_valid)) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                issue     = 1'b1;
                sel0      = r_ir[8:6];
                sel1      = r_ir[5:3];
                alu_op    = r_ir[11:9];
                dst       = r_ir[2:0];
                // Both muxes share one FIFO head, so a doubled select pops once
                neigh_pop = (r_ir[8:6] == c_sel_neigh) || (r_ir[5:3] == c_sel_neigh);
                bus_pop   = (r_ir[8:6] == c_sel_bus)   || (r_ir[5:3] == c_sel_bus);
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_pc_inc    = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_len   <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_acc) begin
                r_pc  <= '0;
                r_len <= prog_len;
            end else if (w_pc_inc) begin
                r_pc <= r_pc + c_one;
            end
            if (w_ir_load) begin
                r_ir <= inst_data;
            end
        end
    end

`ifdef STALL_CNT_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stall <= 16'd0;
        end else if (w_start_acc) begin
            r_stall <= 16'd0;
        end else if (r_state == S_WAIT && r_stall != 16'hFFFF) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign stall_cycles = r_stall;
`endif

endmodule
`default_nettype wire
